// File: rtl/bin_bbox_detect_if.sv
// Video-in, video-out and per-frame box result bundle around bin_bbox_detect.
// Pixel stream has no backpressure: the source is the master, the detector is the slave.
interface bin_bbox_detect_if;
    logic        per_img_vsync;
    logic        per_img_href;
    logic [7:0]  per_img_gray;
    logic        post_img_vsync;
    logic        post_img_href;
    logic [7:0]  post_img_gray;
    logic        box_valid;
    logic        box_found;
    logic [10:0] box_xmin;
    logic [10:0] box_xmax;
    logic [10:0] box_ymin;
    logic [10:0] box_ymax;
    logic [19:0] box_count;

    modport master (
        output per_img_vsync, per_img_href, per_img_gray,
        input  post_img_vsync, post_img_href, post_img_gray,
        input  box_valid, box_found, box_xmin, box_xmax, box_ymin, box_ymax, box_count
    );

    modport slave (
        input  per_img_vsync, per_img_href, per_img_gray,
        output post_img_vsync, post_img_href, post_img_gray,
        output box_valid, box_found, box_xmin, box_xmax, box_ymin, box_ymax, box_count
    );
endinterface

// File: rtl/bin_bbox_detect.sv
// Foreground bounding box + pixel count per frame, with last frame's box overlaid on the video.
// Video latency 2 clocks; box_valid 3 clocks after vsync falls; no backpressure (stream never stalls).
module bin_bbox_detect #(
    parameter logic [10:0] IMG_HDISP  = 11'd640,
    parameter logic [10:0] IMG_VDISP  = 11'd480,
    parameter logic [19:0] MIN_PIXELS = 20'd16,
    parameter logic [7:0]  BOX_GRAY   = 8'd128
) (
    input  logic           clk,
    input  logic           rst,
    bin_bbox_detect_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, LATCH} state_t;

    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [19:0] PIX_MAX = 20'hFFFFF;

    state_t      state_q, state_d;
    logic        s1_vsync_q, s1_href_q;
    logic [7:0]  s1_gray_q;
    logic        post_vsync_q, post_href_q;
    logic [7:0]  post_gray_q;
    logic        armed_q;
    logic [10:0] x_cnt_q, y_cnt_q;
    logic [10:0] xmin_q, xmax_q, ymin_q, ymax_q;
    logic [19:0] cnt_q;
    logic        box_valid_q, box_found_q;
    logic [10:0] box_xmin_q, box_xmax_q, box_ymin_q, box_ymax_q;
    logic [19:0] box_count_q;

    logic vsync_rise, vsync_fall, href_fall, fg_pix;
    logic init, acc, latch;
    logic on_col, on_row, border;

    // A vsync already high when reset is released must not look like a frame start.
    assign vsync_rise = s1_vsync_q & ~post_vsync_q & armed_q;
    assign vsync_fall = ~s1_vsync_q & post_vsync_q;
    assign href_fall  = ~s1_href_q & post_href_q;
    assign fg_pix     = s1_href_q && (s1_gray_q == 8'd0) &&
                        (x_cnt_q < IMG_HDISP) && (y_cnt_q < IMG_VDISP);

    always_comb begin
        state_d = state_q;
        init    = 1'b0;
        acc     = 1'b0;
        latch   = 1'b0;
        if (vsync_rise) begin
            state_d = ACTIVE;
            init    = 1'b1;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                ACTIVE: begin
                    acc = fg_pix;
                    if (vsync_fall) state_d = LATCH;
                end
                LATCH: begin
                    latch   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vsync_q   <= 1'b0;
            s1_href_q    <= 1'b0;
            s1_gray_q    <= 8'd0;
            post_vsync_q <= 1'b0;
            post_href_q  <= 1'b0;
            post_gray_q  <= 8'd0;
            armed_q      <= 1'b0;
            x_cnt_q      <= 11'd0;
            y_cnt_q      <= 11'd0;
        end else begin
            s1_vsync_q   <= bus.per_img_vsync;
            s1_href_q    <= bus.per_img_href;
            s1_gray_q    <= bus.per_img_gray;
            post_vsync_q <= s1_vsync_q;
            post_href_q  <= s1_href_q;
            post_gray_q  <= border ? BOX_GRAY : s1_gray_q;
            armed_q      <= armed_q | ~bus.per_img_vsync;
            if (!s1_href_q)             x_cnt_q <= 11'd0;
            else if (x_cnt_q != CNT_MAX) x_cnt_q <= x_cnt_q + 11'd1;
            if (vsync_rise)                           y_cnt_q <= 11'd0;
            else if (href_fall && y_cnt_q != CNT_MAX) y_cnt_q <= y_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xmin_q <= CNT_MAX;
            xmax_q <= 11'd0;
            ymin_q <= CNT_MAX;
            ymax_q <= 11'd0;
            cnt_q  <= 20'd0;
        end else if (init) begin
            xmin_q <= CNT_MAX;
            xmax_q <= 11'd0;
            ymin_q <= CNT_MAX;
            ymax_q <= 11'd0;
            cnt_q  <= 20'd0;
        end else if (acc) begin
            if (x_cnt_q < xmin_q) xmin_q <= x_cnt_q;
            if (x_cnt_q > xmax_q) xmax_q <= x_cnt_q;
            if (y_cnt_q < ymin_q) ymin_q <= y_cnt_q;
            if (y_cnt_q > ymax_q) ymax_q <= y_cnt_q;
            if (cnt_q != PIX_MAX) cnt_q <= cnt_q + 20'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_valid_q <= 1'b0;
            box_found_q <= 1'b0;
            box_xmin_q  <= 11'd0;
            box_xmax_q  <= 11'd0;
            box_ymin_q  <= 11'd0;
            box_ymax_q  <= 11'd0;
            box_count_q <= 20'd0;
        end else begin
            box_valid_q <= latch;
            if (latch) begin
                box_count_q <= cnt_q;
                box_found_q <= (cnt_q >= MIN_PIXELS);
                if (cnt_q >= MIN_PIXELS) begin
                    box_xmin_q <= xmin_q;
                    box_xmax_q <= xmax_q;
                    box_ymin_q <= ymin_q;
                    box_ymax_q <= ymax_q;
                end else begin
                    box_xmin_q <= 11'd0;
                    box_xmax_q <= 11'd0;
                    box_ymin_q <= 11'd0;
                    box_ymax_q <= 11'd0;
                end
            end
        end
    end

    // Box registers only move in LATCH, while href is low, so a drawn frame never tears.
    assign on_col = ((x_cnt_q == box_xmin_q) || (x_cnt_q == box_xmax_q)) &&
                    (y_cnt_q >= box_ymin_q) && (y_cnt_q <= box_ymax_q);
    assign on_row = ((y_cnt_q == box_ymin_q) || (y_cnt_q == box_ymax_q)) &&
                    (x_cnt_q >= box_xmin_q) && (x_cnt_q <= box_xmax_q);
    assign border = box_found_q && s1_href_q && (on_col || on_row);

    assign bus.post_img_vsync = post_vsync_q;
    assign bus.post_img_href  = post_href_q;
    assign bus.post_img_gray  = post_gray_q;
    assign bus.box_valid      = box_valid_q;
    assign bus.box_found      = box_found_q;
    assign bus.box_xmin       = box_xmin_q;
    assign bus.box_xmax       = box_xmax_q;
    assign bus.box_ymin       = box_ymin_q;
    assign bus.box_ymax       = box_ymax_q;
    assign bus.box_count      = box_count_q;
endmodule

// File: tb/tb_bin_bbox_detect.sv
// Directed bench: one 16x8 stimulus stream drives three detectors with MIN_PIXELS 4, 13 and 1.
module tb_bin_bbox_detect;
    logic       clk = 1'b0;
    logic       rst;
    logic       vs, hs;
    logic [7:0] px;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         fall_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_bbox_detect_if if_a ();
    bin_bbox_detect_if if_b ();
    bin_bbox_detect_if if_c ();

    assign {if_a.per_img_vsync, if_a.per_img_href, if_a.per_img_gray} = {vs, hs, px};
    assign {if_b.per_img_vsync, if_b.per_img_href, if_b.per_img_gray} = {vs, hs, px};
    assign {if_c.per_img_vsync, if_c.per_img_href, if_c.per_img_gray} = {vs, hs, px};

    bin_bbox_detect #(.IMG_HDISP(11'd16), .IMG_VDISP(11'd8), .MIN_PIXELS(20'd4),  .BOX_GRAY(8'd128))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    bin_bbox_detect #(.IMG_HDISP(11'd16), .IMG_VDISP(11'd8), .MIN_PIXELS(20'd13), .BOX_GRAY(8'd128))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    bin_bbox_detect #(.IMG_HDISP(11'd16), .IMG_VDISP(11'd8), .MIN_PIXELS(20'd1),  .BOX_GRAY(8'd128))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    logic        pv [3], ph [3], bv [3], bf [3];
    logic [7:0]  pg [3];
    logic [10:0] bx0 [3], bx1 [3], by0 [3], by1 [3];
    logic [19:0] bc [3];

    assign {pv[0], ph[0], pg[0], bv[0], bf[0], bx0[0], bx1[0], by0[0], by1[0], bc[0]} =
           {if_a.post_img_vsync, if_a.post_img_href, if_a.post_img_gray, if_a.box_valid, if_a.box_found,
            if_a.box_xmin, if_a.box_xmax, if_a.box_ymin, if_a.box_ymax, if_a.box_count};
    assign {pv[1], ph[1], pg[1], bv[1], bf[1], bx0[1], bx1[1], by0[1], by1[1], bc[1]} =
           {if_b.post_img_vsync, if_b.post_img_href, if_b.post_img_gray, if_b.box_valid, if_b.box_found,
            if_b.box_xmin, if_b.box_xmax, if_b.box_ymin, if_b.box_ymax, if_b.box_count};
    assign {pv[2], ph[2], pg[2], bv[2], bf[2], bx0[2], bx1[2], by0[2], by1[2], bc[2]} =
           {if_c.post_img_vsync, if_c.post_img_href, if_c.post_img_gray, if_c.box_valid, if_c.box_found,
            if_c.box_xmin, if_c.box_xmax, if_c.box_ymin, if_c.box_ymax, if_c.box_count};

    // Reference two-clock delay line for the video signals.
    logic       vs1, vs2, hs1, hs2;
    logic [7:0] px1, px2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {vs1, vs2, hs1, hs2} <= 4'b0;
            px1 <= 8'd0;
            px2 <= 8'd0;
        end else begin
            vs1 <= vs;  vs2 <= vs1;
            hs1 <= hs;  hs2 <= hs1;
            px1 <= px;  px2 <= px1;
        end
    end

    // Output observer: tallies and a captured output image per detector.
    int         bv_cnt [3], n128 [3], gdiff [3], lat_err [3], bv_cyc [3], ox [3], oy [3];
    logic       pv_p [3], ph_p [3];
    logic [7:0] img [3][8][16];
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                pv_p[i] = 1'b0; ph_p[i] = 1'b0; ox[i] = 0; oy[i] = 0;
            end else begin
                if (pv[i] && !pv_p[i]) oy[i] = 0;
                if (ph[i]) begin
                    if (ox[i] < 16 && oy[i] < 8) img[i][oy[i]][ox[i]] = pg[i];
                    if (pg[i] == 8'd128) n128[i]++;
                    if (pg[i] !== px2) gdiff[i]++;
                    ox[i]++;
                end else begin
                    if (ph_p[i]) oy[i]++;
                    ox[i] = 0;
                end
                if (pv[i] !== vs2 || ph[i] !== hs2) lat_err[i]++;
                if (bv[i]) begin bv_cnt[i]++; bv_cyc[i] = cyc; end
                pv_p[i] = pv[i];
                ph_p[i] = ph[i];
            end
        end
    end

    int s_bv [3], s_n128 [3], s_gd [3];

    task automatic snap();
        for (int i = 0; i < 3; i++) begin
            s_bv[i] = bv_cnt[i]; s_n128[i] = n128[i]; s_gd[i] = gdiff[i];
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int mode, input int x, input int y);
        if (mode == 1) return (x >= 4 && x <= 7 && y >= 2 && y <= 4) ? 8'd0 : 8'd255;
        if (mode == 2) return (x == 15 && y == 7) ? 8'd0 : 8'd255;
        return 8'd255;
    endfunction

    task automatic frame_start();
        @(negedge clk); vs = 1'b1; hs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_row(input int mode, input int y);
        for (int x = 0; x < 16; x++) begin
            @(negedge clk); hs = 1'b1; px = pix(mode, x, y);
        end
        repeat (4) begin
            @(negedge clk); hs = 1'b0; px = 8'd0;
        end
    endtask

    task automatic frame_end();
        @(negedge clk); vs = 1'b0; fall_cyc = cyc;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input int mode);
        frame_start();
        for (int y = 0; y < 8; y++) send_row(mode, y);
        frame_end();
    endtask

    initial begin
        rst = 1'b1; vs = 1'b0; hs = 1'b0; px = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_post_vsync", pv[0], 0);
        chk("rst_post_gray",  pg[0], 0);
        chk("rst_box_valid",  bv[0], 0);
        chk("rst_box_all",    {bf[0], bx0[0], bx1[0], by0[0], by1[0], bc[0]}, 0);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);

        // All-background frame
        snap(); send_frame(0);
        chk("f1_valid_pulses", bv_cnt[0] - s_bv[0], 1);
        chk("f1_valid_delay",  bv_cyc[0] - fall_cyc, 3);
        chk("f1_found",        bf[0], 0);
        chk("f1_count",        bc[0], 0);
        chk("f1_coords",       {bx0[0], bx1[0], by0[0], by1[0]}, 0);
        chk("f1_gray_passthru", gdiff[0] - s_gd[0], 0);

        // 4x3 foreground block
        snap(); send_frame(1);
        chk("f2_valid_pulses", bv_cnt[0] - s_bv[0], 1);
        chk("f2_found",  bf[0], 1);
        chk("f2_xmin",   bx0[0], 4);
        chk("f2_xmax",   bx1[0], 7);
        chk("f2_ymin",   by0[0], 2);
        chk("f2_ymax",   by1[0], 4);
        chk("f2_count",  bc[0], 12);
        chk("f2_gray_passthru", gdiff[0] - s_gd[0], 0);
        chk("f2_b_found",  bf[1], 0);
        chk("f2_b_count",  bc[1], 12);
        chk("f2_b_coords", {bx0[1], bx1[1], by0[1], by1[1]}, 0);
        chk("f2_c_found",  bf[2], 1);

        // Background frame carrying the block's overlay
        snap(); send_frame(0);
        chk("f3_n128",       n128[0] - s_n128[0], 10);
        chk("f3_gray_diffs", gdiff[0] - s_gd[0], 10);
        chk("f3_pix_5_3",    img[0][3][5], 255);
        chk("f3_pix_6_3",    img[0][3][6], 255);
        chk("f3_pix_4_2",    img[0][2][4], 128);
        chk("f3_pix_7_4",    img[0][4][7], 128);
        chk("f3_pix_4_1",    img[0][1][4], 255);
        chk("f3_found",      bf[0], 0);
        chk("f3_b_no_overlay", n128[1] - s_n128[1], 0);
        chk("f3_b_gray_passthru", gdiff[1] - s_gd[1], 0);

        send_frame(1);
        chk("f4_found", bf[0], 1);

        // Reset pulsed mid-frame
        snap(); frame_start();
        for (int y = 0; y < 4; y++) send_row(1, y);
        chk("f5_pre_rst_vsync", pv[0], 1);
        @(negedge clk); rst = 1'b1; #1;
        chk("f5_rst_post_vsync", pv[0], 0);
        chk("f5_rst_found",      bf[0], 0);
        chk("f5_rst_coords",     {bx0[0], bx1[0], by0[0], by1[0]}, 0);
        chk("f5_rst_count",      bc[0], 0);
        repeat (2) @(negedge clk); rst = 1'b0;
        for (int y = 4; y < 8; y++) send_row(1, y);
        frame_end();
        chk("f5_no_valid_a", bv_cnt[0] - s_bv[0], 0);
        chk("f5_no_valid_b", bv_cnt[1] - s_bv[1], 0);

        snap(); send_frame(1);
        chk("f6_valid_pulses", bv_cnt[0] - s_bv[0], 1);
        chk("f6_box", {bf[0], bx0[0], bx1[0], by0[0], by1[0], bc[0]},
                      {1'b1, 11'd4, 11'd7, 11'd2, 11'd4, 20'd12});

        // Reset released while vsync is already high
        snap();
        @(negedge clk); rst = 1'b1;
        frame_start();
        @(negedge clk); rst = 1'b0;
        for (int y = 0; y < 8; y++) send_row(1, y);
        frame_end();
        chk("f7_no_valid_a", bv_cnt[0] - s_bv[0], 0);
        chk("f7_no_valid_c", bv_cnt[2] - s_bv[2], 0);

        // Single foreground pixel in the bottom-right corner
        snap(); send_frame(2);
        chk("f8_valid_pulses", bv_cnt[0] - s_bv[0], 1);
        chk("f8_a_found",  bf[0], 0);
        chk("f8_a_count",  bc[0], 1);
        chk("f8_a_coords", {bx0[0], bx1[0], by0[0], by1[0]}, 0);
        chk("f8_c_found",  bf[2], 1);
        chk("f8_c_box", {bx0[2], bx1[2], by0[2], by1[2], bc[2]},
                        {11'd15, 11'd15, 11'd7, 11'd7, 20'd1});

        snap(); send_frame(0);
        chk("f9_c_n128",      n128[2] - s_n128[2], 1);
        chk("f9_c_pix_15_7",  img[2][7][15], 128);
        chk("f9_c_pix_14_7",  img[2][7][14], 255);
        chk("f9_a_no_overlay", n128[0] - s_n128[0], 0);

        chk("latency_a", lat_err[0], 0);
        chk("latency_b", lat_err[1], 0);
        chk("latency_c", lat_err[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bin_bbox_detect.md
Name: bin_bbox_detect

Overview:
- Consumes the binarized stream from the region binarization stage: 0 is foreground, any nonzero value is background.
- Per frame, tracks the bounding box and pixel count of the foreground. Latches the results at frame end with a one-cycle valid pulse.
- Passes the video through with the previous frame's box drawn as an overlay. Sits between the binarizer and the display/VGA output path.

Parameters:
IMG_HDISP, 11'd640, active pixels per line
IMG_VDISP, 11'd480, active lines per frame
MIN_PIXELS, 20'd16, minimum foreground count for a box to be declared found
BOX_GRAY, 8'd128, gray value drawn on the box border

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
per_img_vsync  in  1  input frame valid
per_img_href  in  1  input line valid
per_img_gray  in  8  binarized pixel (0 = foreground)
post_img_vsync  out  1  per_img_vsync delayed by 2 clocks
post_img_href  out  1  per_img_href delayed by 2 clocks
post_img_gray  out  8  pixel with box overlay, 2-clock latency
box_valid  out  1  one-cycle pulse: new frame results on box_*
box_found  out  1  last frame count >= MIN_PIXELS
box_xmin  out  11  left column of last box
box_xmax  out  11  right column
box_ymin  out  11  top row
box_ymax  out  11  bottom row
box_count  out  20  last frame foreground pixel count

Behaviour:
- Reset: clk and rst only, one clock domain. Reset is asynchronous and active-high.
  - All outputs go to 0, the FSM goes to IDLE, and the box registers clear.
  - The reset takes effect immediately, even mid-frame.
- Edge detection: vsync and href are registered once (vsync_d, href_d).
  - Vsync rise = vsync & ~vsync_d. Vsync fall = ~vsync & vsync_d.
- Counters:
  - x_cnt increments per pixel with href high. It clears when href is low and saturates at 2047.
  - y_cnt increments on each href falling edge, clears on vsync rise, and saturates at 2047.
  - A pixel counts toward the statistics only if x_cnt < IMG_HDISP and y_cnt < IMG_VDISP.
- FSM: IDLE -> ACTIVE -> LATCH -> IDLE.
  - IDLE: wait for vsync rise. A frame already in progress at reset release is ignored entirely.
  - On vsync rise, go to ACTIVE and initialise the running registers: xmin = ymin = 2047, xmax = ymax = 0, count = 0.
  - ACTIVE: for each in-range foreground pixel:
    - xmin = min(xmin, x), xmax = max(xmax, x); ymin and ymax likewise on y.
    - count increments and saturates at 2^20-1.
  - ACTIVE: on vsync fall, go to LATCH.
  - LATCH (1 cycle): box_count <= count; box_found <= (count >= MIN_PIXELS).
    - If found, load box_xmin/xmax/ymin/ymax from the running registers.
    - If not found, load all four as 0.
    - Return to IDLE.
- box_valid: high exactly one clock, in the cycle after LATCH.
  - box_* already hold the new values when it rises, and stay stable until the next LATCH.
  - Net timing: box_valid rises 3 clocks after per_img_vsync falls.
- Vsync rise seen in any state other than IDLE: abandon the current accumulation and restart ACTIVE with re-initialised registers. No box_valid is issued for the abandoned frame.
- Overlay, on the stage-1 registered pixel with coordinates (x, y):
  - The pixel is a border pixel if box_found and href, and either:
    - x == box_xmin or x == box_xmax, with ymin <= y <= ymax; or
    - y == box_ymin or y == box_ymax, with xmin <= x <= xmax.
  - post_img_gray = BOX_GRAY on border pixels, otherwise the input gray.
  - The box registers change only in LATCH (href low), so no frame tears.
- Latency: post_img_vsync, post_img_href and post_img_gray are exactly 2 clocks after the input. The overlay does not alter vsync or href.

Test Plan:
Run all scenarios with IMG_HDISP=16, IMG_VDISP=8 and 4-clock horizontal blanking.
1. All-255 frame -> one box_valid pulse; box_found=0; box_count=0; all coordinates 0; post_img_gray identical to the input, delayed 2 clocks.
2. Block of 0 at x=4..7, y=2..4, MIN_PIXELS=4 -> box_xmin=4, box_xmax=7, box_ymin=2, box_ymax=4, box_count=12, box_found=1.
3. Same frame with MIN_PIXELS=13 -> box_found=0, box_count=12, coordinates 0; the next frame has no overlay.
4. Scenario 2 followed by an all-255 frame:
   - exactly 10 output pixels = 128 (perimeter of x4..7, y2..4);
   - pixels (5,3) and (6,3) = 255;
   - the second frame reports box_found=0.
5. rst pulsed mid-frame after row 3 -> all outputs 0 immediately; no box_valid for that frame; the following full frame with scenario 2's block reports the scenario 2 values.
6. Reset released while vsync is high with foreground present -> no box_valid at that vsync fall; the next complete frame is reported correctly.
7. Single foreground pixel at (15,7), MIN_PIXELS=1 -> xmin=xmax=15, ymin=ymax=7, count=1; one overlay pixel at (15,7) in the next frame.
